// File: rtl/float_signed_narrow_pipe.sv
// Two-stage, multi-lane narrowing rounder for sign/inf/zero/exp/frac floats.
// S1 captures the kept bits and the round-up decision; S2 applies the increment and exponent carry.
module float_signed_narrow_pipe #(
   parameter int unsigned IN_FRAC       = 10,
   parameter int unsigned OUT_FRAC      = 8,
   parameter int unsigned EXP           = 8,
   parameter int unsigned TRAILING_BITS = 2,
   parameter int unsigned LANES         = 1,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input  logic                              clock,
   input  logic                              resetn,
   input  logic                              inValid,
   output logic                              inReady,
   input  logic [LANES-1:0]                  inSign,
   input  logic [LANES-1:0]                  inIsInf,
   input  logic [LANES-1:0]                  inIsZero,
   input  logic [LANES*EXP-1:0]              inExp,
   input  logic [LANES*IN_FRAC-1:0]          inFrac,
   input  logic [LANES*TRAILING_BITS-1:0]    inTrailing,
   input  logic [LANES-1:0]                  inSticky,
   input  logic [1:0]                        roundMode,
   output logic                              outValid,
   input  logic                              outReady,
   output logic [LANES-1:0]                  outSign,
   output logic [LANES-1:0]                  outIsInf,
   output logic [LANES-1:0]                  outIsZero,
   output logic [LANES*EXP-1:0]              outExp,
   output logic [LANES*OUT_FRAC-1:0]         outFrac,
   output logic [LANES-1:0]                  outInexact,
   output logic [LANES-1:0]                  outOverflow,
   input  logic                              statClear,
   output logic [CNT_WIDTH-1:0]              inexactCount
);

   localparam int unsigned W   = IN_FRAC + TRAILING_BITS;
   localparam int unsigned LOW = W - 1 - OUT_FRAC;

   logic                              s1_valid_q, s1_valid_d;
   logic [LANES-1:0]                  s1_sign_q, s1_sign_d;
   logic [LANES-1:0]                  s1_inf_q, s1_inf_d;
   logic [LANES-1:0]                  s1_zero_q, s1_zero_d;
   logic [LANES-1:0][EXP-1:0]         s1_exp_q, s1_exp_d;
   logic [LANES-1:0][OUT_FRAC-1:0]    s1_kept_q, s1_kept_d;
   logic [LANES-1:0]                  s1_inc_q, s1_inc_d;
   logic [LANES-1:0]                  s1_inexact_q, s1_inexact_d;

   logic                              s2_valid_q, s2_valid_d;
   logic [LANES-1:0]                  s2_sign_q, s2_sign_d;
   logic [LANES-1:0]                  s2_inf_q, s2_inf_d;
   logic [LANES-1:0]                  s2_zero_q, s2_zero_d;
   logic [LANES-1:0][EXP-1:0]         s2_exp_q, s2_exp_d;
   logic [LANES-1:0][OUT_FRAC-1:0]    s2_frac_q, s2_frac_d;
   logic [LANES-1:0]                  s2_inexact_q, s2_inexact_d;
   logic [LANES-1:0]                  s2_ovf_q, s2_ovf_d;

   logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;

   logic                              s1_adv;
   logic                              in_fire;
   logic [W-1:0]                      full;
   logic                              rnd_bit;
   logic                              stk_bit;
   logic                              inexact;
   logic [OUT_FRAC:0]                 sum;

   assign s1_adv  = !s2_valid_q | outReady;
   assign inReady = !s1_valid_q | s1_adv;
   assign in_fire = inValid & inReady;

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_sign_d    = s1_sign_q;
      s1_inf_d     = s1_inf_q;
      s1_zero_d    = s1_zero_q;
      s1_exp_d     = s1_exp_q;
      s1_kept_d    = s1_kept_q;
      s1_inc_d     = s1_inc_q;
      s1_inexact_d = s1_inexact_q;
      full         = '0;
      rnd_bit      = 1'b0;
      stk_bit      = 1'b0;
      inexact      = 1'b0;
      if (inReady) begin
         s1_valid_d = inValid;
      end
      if (in_fire) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            full    = {inFrac[i*IN_FRAC +: IN_FRAC], inTrailing[i*TRAILING_BITS +: TRAILING_BITS]};
            rnd_bit = full[LOW];
            stk_bit = inSticky[i];
            for (int unsigned b = 0; b < LOW; b++) begin
               stk_bit = stk_bit | full[b];
            end
            inexact      = rnd_bit | stk_bit;
            s1_sign_d[i] = inSign[i];
            s1_inf_d[i]  = inIsInf[i];
            s1_zero_d[i] = inIsZero[i];
            s1_exp_d[i]  = inExp[i*EXP +: EXP];
            // Specials bypass rounding: zeroing kept/inc makes S2 produce frac 0 with no carry.
            if (inIsInf[i] | inIsZero[i]) begin
               s1_kept_d[i]    = '0;
               s1_inc_d[i]     = 1'b0;
               s1_inexact_d[i] = 1'b0;
            end else begin
               s1_kept_d[i]    = full[W-1 -: OUT_FRAC];
               s1_inexact_d[i] = inexact;
               case (roundMode)
                  2'd0:    s1_inc_d[i] = rnd_bit & (stk_bit | full[LOW+1]);
                  2'd1:    s1_inc_d[i] = 1'b0;
                  2'd2:    s1_inc_d[i] = inexact & !inSign[i];
                  default: s1_inc_d[i] = inexact & inSign[i];
               endcase
            end
         end
      end
   end

   always_comb begin
      s2_valid_d   = s2_valid_q;
      s2_sign_d    = s2_sign_q;
      s2_inf_d     = s2_inf_q;
      s2_zero_d    = s2_zero_q;
      s2_exp_d     = s2_exp_q;
      s2_frac_d    = s2_frac_q;
      s2_inexact_d = s2_inexact_q;
      s2_ovf_d     = s2_ovf_q;
      sum          = '0;
      if (s1_adv) begin
         s2_valid_d = s1_valid_q;
      end
      if (s1_adv & s1_valid_q) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            sum             = {1'b0, s1_kept_q[i]} + {{OUT_FRAC{1'b0}}, s1_inc_q[i]};
            s2_sign_d[i]    = s1_sign_q[i];
            s2_zero_d[i]    = s1_zero_q[i];
            s2_inexact_d[i] = s1_inexact_q[i];
            s2_frac_d[i]    = sum[OUT_FRAC-1:0];
            s2_inf_d[i]     = s1_inf_q[i];
            s2_exp_d[i]     = s1_exp_q[i];
            s2_ovf_d[i]     = 1'b0;
            if (sum[OUT_FRAC]) begin
               if (s1_exp_q[i] == '1) begin
                  s2_inf_d[i] = 1'b1;
                  s2_ovf_d[i] = 1'b1;
               end else begin
                  s2_exp_d[i] = s1_exp_q[i] + {{(EXP-1){1'b0}}, 1'b1};
               end
            end
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (statClear) begin
         cnt_d = '0;
      end else if (s2_valid_q & outReady & (|s2_inexact_q) & (cnt_q != '1)) begin
         cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_valid_q   <= 1'b0;
         s1_sign_q    <= '0;
         s1_inf_q     <= '0;
         s1_zero_q    <= '0;
         s1_exp_q     <= '0;
         s1_kept_q    <= '0;
         s1_inc_q     <= '0;
         s1_inexact_q <= '0;
         s2_valid_q   <= 1'b0;
         s2_sign_q    <= '0;
         s2_inf_q     <= '0;
         s2_zero_q    <= '0;
         s2_exp_q     <= '0;
         s2_frac_q    <= '0;
         s2_inexact_q <= '0;
         s2_ovf_q     <= '0;
         cnt_q        <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_sign_q    <= s1_sign_d;
         s1_inf_q     <= s1_inf_d;
         s1_zero_q    <= s1_zero_d;
         s1_exp_q     <= s1_exp_d;
         s1_kept_q    <= s1_kept_d;
         s1_inc_q     <= s1_inc_d;
         s1_inexact_q <= s1_inexact_d;
         s2_valid_q   <= s2_valid_d;
         s2_sign_q    <= s2_sign_d;
         s2_inf_q     <= s2_inf_d;
         s2_zero_q    <= s2_zero_d;
         s2_exp_q     <= s2_exp_d;
         s2_frac_q    <= s2_frac_d;
         s2_inexact_q <= s2_inexact_d;
         s2_ovf_q     <= s2_ovf_d;
         cnt_q        <= cnt_d;
      end
   end

   assign outValid     = s2_valid_q;
   assign outSign      = s2_sign_q;
   assign outIsInf     = s2_inf_q;
   assign outIsZero    = s2_zero_q;
   assign outExp       = s2_exp_q;
   assign outFrac      = s2_frac_q;
   assign outInexact   = s2_inexact_q;
   assign outOverflow  = s2_ovf_q;
   assign inexactCount = cnt_q;

endmodule

// File: tb/tb_float_signed_narrow_pipe.sv
// Bench for float_signed_narrow_pipe: an arithmetic rounding model feeds a scoreboard checked every cycle,
// plus directed beats with literal expected outputs.
module tb_float_signed_narrow_pipe;

   localparam int LANES = 2;
   localparam int CW    = 4;

   logic                clock = 1'b0;
   logic                resetn = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [LANES-1:0]    in_sign = '0, in_inf = '0, in_zero = '0, in_sticky = '0;
   logic [LANES*8-1:0]  in_exp = '0;
   logic [LANES*10-1:0] in_frac = '0;
   logic [LANES*2-1:0]  in_trail = '0;
   logic [1:0]          round_mode = '0;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic [LANES-1:0]    out_sign, out_inf, out_zero, out_inexact, out_ovf;
   logic [LANES*8-1:0]  out_exp;
   logic [LANES*8-1:0]  out_frac;
   logic                stat_clear = 1'b0;
   logic [CW-1:0]       inexact_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   float_signed_narrow_pipe #(
      .IN_FRAC(10), .OUT_FRAC(8), .EXP(8), .TRAILING_BITS(2), .LANES(LANES), .CNT_WIDTH(CW)
   ) dut (
      .clock(clock), .resetn(resetn), .inValid(in_valid), .inReady(in_ready),
      .inSign(in_sign), .inIsInf(in_inf), .inIsZero(in_zero), .inExp(in_exp),
      .inFrac(in_frac), .inTrailing(in_trail), .inSticky(in_sticky), .roundMode(round_mode),
      .outValid(out_valid), .outReady(out_ready), .outSign(out_sign), .outIsInf(out_inf),
      .outIsZero(out_zero), .outExp(out_exp), .outFrac(out_frac), .outInexact(out_inexact),
      .outOverflow(out_ovf), .statClear(stat_clear), .inexactCount(inexact_count)
   );

   typedef struct packed {
      logic       sign;
      logic       inf;
      logic       zero;
      logic [7:0] exp;
      logic [7:0] frac;
      logic       inexact;
      logic       ovf;
   } lane_t;
   typedef lane_t [LANES-1:0] beat_t;

   beat_t q[$];
   int    cnt_m = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, got, want);
      end
   endtask

   // Value-level rounding: remainder below the kept bits compared against one half.
   function automatic lane_t model_lane(input logic s, input logic inf, input logic z,
                                        input logic [7:0] e, input logic [9:0] f,
                                        input logic [1:0] t, input logic st, input logic [1:0] m);
      lane_t       o;
      int unsigned full, kept, rem2, res;
      logic        up, ix;
      full = {20'd0, f, t};
      kept = full / 16;
      rem2 = (full % 16) * 2 + (st ? 1 : 0);
      ix   = (rem2 != 0);
      case (m)
         2'd0:    up = (rem2 > 16) || (rem2 == 16 && (kept % 2) == 1);
         2'd1:    up = 1'b0;
         2'd2:    up = ix && !s;
         default: up = ix && s;
      endcase
      res       = kept + (up ? 1 : 0);
      o.sign    = s;
      o.inf     = inf;
      o.zero    = z;
      o.exp     = e;
      o.ovf     = 1'b0;
      o.inexact = ix;
      o.frac    = 8'(res % 256);
      if (res == 256) begin
         o.frac = 8'd0;
         if (e == 8'd255) begin
            o.inf = 1'b1;
            o.ovf = 1'b1;
         end else begin
            o.exp = e + 8'd1;
         end
      end
      if (inf || z) begin
         o.inf = inf; o.exp = e; o.frac = 8'd0; o.inexact = 1'b0; o.ovf = 1'b0;
      end
      return o;
   endfunction

   always @(negedge clock) begin
      beat_t b;
      lane_t g;
      logic  any_ix;
      if (!resetn) begin
         q.delete();
         cnt_m = 0;
      end else begin
         chk("inexact_count", 64'(inexact_count), 64'(cnt_m));
         any_ix = 1'b0;
         if (out_valid) begin
            chk("beat_expected", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
               for (int l = 0; l < LANES; l++) begin
                  g.sign = out_sign[l]; g.inf = out_inf[l]; g.zero = out_zero[l];
                  g.exp = out_exp[l*8 +: 8]; g.frac = out_frac[l*8 +: 8];
                  g.inexact = out_inexact[l]; g.ovf = out_ovf[l];
                  chk($sformatf("lane%0d_out", l), 64'(g), 64'(q[0][l]));
                  any_ix = any_ix | q[0][l].inexact;
               end
               if (out_ready) void'(q.pop_front());
               else any_ix = 1'b0;
            end
         end
         if (stat_clear) cnt_m = 0;
         else if (out_valid && out_ready && any_ix && cnt_m < 15) cnt_m++;
         if (in_valid && in_ready) begin
            for (int l = 0; l < LANES; l++)
               b[l] = model_lane(in_sign[l], in_inf[l], in_zero[l], in_exp[l*8 +: 8],
                                 in_frac[l*10 +: 10], in_trail[l*2 +: 2], in_sticky[l], round_mode);
            q.push_back(b);
         end
      end
   end

   task automatic set_lane(input int l, input logic s, input logic inf, input logic z,
                           input logic [7:0] e, input logic [9:0] f, input logic [1:0] t, input logic st);
      in_sign[l] = s; in_inf[l] = inf; in_zero[l] = z; in_sticky[l] = st;
      in_exp[l*8 +: 8] = e; in_frac[l*10 +: 10] = f; in_trail[l*2 +: 2] = t;
   endtask

   task automatic push(input logic [1:0] m);
      int n = 0;
      round_mode = m;
      in_valid   = 1'b1;
      do begin
         @(negedge clock);
         n++;
      end while (!in_ready && n < 50);
      if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string nm, input logic [7:0] f, input logic [7:0] e,
                             input logic ix, input logic ov, input logic inf, input logic z);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!out_valid && n < 10);
      chk({nm, "_latency"}, 64'(n), 64'd2);
      chk({nm, "_frac"}, 64'(out_frac[7:0]), 64'(f));
      chk({nm, "_exp"}, 64'(out_exp[7:0]), 64'(e));
      chk({nm, "_inexact"}, 64'(out_inexact[0]), 64'(ix));
      chk({nm, "_ovf"}, 64'(out_ovf[0]), 64'(ov));
      chk({nm, "_inf"}, 64'(out_inf[0]), 64'(inf));
      chk({nm, "_zero"}, 64'(out_zero[0]), 64'(z));
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while (q.size() != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      #1;
      chk("reset_outValid", 64'(out_valid), 64'd0);
      chk("reset_inReady", 64'(in_ready), 64'd1);
      chk("reset_count", 64'(inexact_count), 64'd0);
      chk("reset_frac", 64'(out_frac), 64'd0);
      chk("reset_exp", 64'(out_exp), 64'd0);
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;

      set_lane(0, 1'b0, 1'b0, 1'b0, 8'd5, 10'b00000001_10, 2'b00, 1'b0);
      set_lane(1, 1'b1, 1'b0, 1'b0, 8'd9, 10'h155, 2'b01, 1'b0);
      push(2'd0);
      expect_out("rne_tie_odd", 8'h02, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      set_lane(0, 1'b0, 1'b0, 1'b0, 8'd5, 10'b00000000_10, 2'b00, 1'b0);
      push(2'd0);
      expect_out("rne_tie_even", 8'h00, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      set_lane(0, 1'b0, 1'b0, 1'b0, 8'd7, 10'h3FF, 2'b11, 1'b0);
      set_lane(1, 1'b0, 1'b0, 1'b0, 8'd254, 10'h3FE, 2'b00, 1'b1);
      push(2'd0);
      expect_out("carry", 8'h00, 8'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      set_lane(0, 1'b0, 1'b0, 1'b0, 8'd255, 10'h3FF, 2'b11, 1'b0);
      push(2'd0);
      expect_out("overflow", 8'h00, 8'd255, 1'b1, 1'b1, 1'b1, 1'b0);

      set_lane(0, 1'b1, 1'b0, 1'b0, 8'd3, 10'b00000100_00, 2'b00, 1'b1);
      set_lane(1, 1'b0, 1'b0, 1'b0, 8'd40, 10'h0FF, 2'b10, 1'b0);
      push(2'd1);
      expect_out("rtz", 8'h04, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      push(2'd2);
      expect_out("pinf_neg", 8'h04, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      push(2'd3);
      expect_out("minf_neg", 8'h05, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      set_lane(0, 1'b0, 1'b0, 1'b0, 8'd3, 10'b00000100_00, 2'b00, 1'b1);
      push(2'd2);
      expect_out("pinf_pos", 8'h05, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);

      set_lane(0, 1'b0, 1'b0, 1'b1, 8'd10, 10'h3FF, 2'b11, 1'b1);
      set_lane(1, 1'b1, 1'b1, 1'b0, 8'd255, 10'h3FF, 2'b11, 1'b1);
      push(2'd2);
      expect_out("special_zero", 8'h00, 8'd10, 1'b0, 1'b0, 1'b0, 1'b1);
      set_lane(0, 1'b1, 1'b1, 1'b0, 8'd255, 10'h2AA, 2'b10, 1'b0);
      push(2'd0);
      expect_out("special_inf", 8'h00, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0);

      // Backpressure: six back-to-back beats while the sink stalls for five cycles.
      fork
         begin
            for (int b = 0; b < 6; b++) begin
               set_lane(0, 1'(b % 2), 1'b0, 1'b0, 8'(20 + b), 10'(b * 77 + 3), 2'(b), 1'((b / 2) % 2));
               set_lane(1, 1'((b / 2) % 2), 1'b0, 1'(b == 5), 8'(250 + b), 10'(1023 - b * 2), 2'(3 - b % 4), 1'(b % 3 == 0));
               push(2'(b % 4));
            end
         end
         begin
            repeat (2) @(posedge clock);
            #1;
            out_ready = 1'b0;
            repeat (4) @(posedge clock);
            @(negedge clock);
            chk("bp_inReady_low", 64'(in_ready), 64'd0);
            chk("bp_beats_held", 64'(q.size()), 64'd2);
            @(posedge clock);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      stat_clear = 1'b1;
      @(posedge clock);
      #1;
      stat_clear = 1'b0;
      set_lane(0, 1'b0, 1'b0, 1'b0, 8'd1, 10'h001, 2'b00, 1'b0);
      set_lane(1, 1'b0, 1'b0, 1'b0, 8'd2, 10'h004, 2'b00, 1'b0);
      for (int i = 0; i < 20; i++) push(2'd1);
      drain();
      @(negedge clock);
      chk("count_saturated", 64'(inexact_count), 64'd15);
      @(posedge clock);
      #1;
      push(2'd0);
      @(posedge clock);
      #1;
      stat_clear = 1'b1;
      @(posedge clock);
      #1;
      stat_clear = 1'b0;
      @(negedge clock);
      chk("clear_beats_accept", 64'(inexact_count), 64'd0);
      @(posedge clock);
      #1;

      push(2'd0);
      drain();
      out_ready = 1'b0;
      set_lane(0, 1'b0, 1'b0, 1'b0, 8'd77, 10'h123, 2'b01, 1'b0);
      push(2'd0);
      set_lane(0, 1'b1, 1'b0, 1'b0, 8'd78, 10'h321, 2'b10, 1'b1);
      push(2'd3);
      #2;
      resetn = 1'b0;
      #1;
      chk("midreset_outValid", 64'(out_valid), 64'd0);
      chk("midreset_inReady", 64'(in_ready), 64'd1);
      chk("midreset_count", 64'(inexact_count), 64'd0);
      chk("midreset_frac", 64'(out_frac), 64'd0);
      chk("midreset_inexact", 64'(out_inexact), 64'd0);
      @(negedge clock);
      @(posedge clock);
      #1;
      resetn = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("no_ghost_beat", 64'(out_valid), 64'd0);
      end
      @(posedge clock);
      #1;
      set_lane(0, 1'b0, 1'b0, 1'b0, 8'd5, 10'b00000001_10, 2'b00, 1'b0);
      push(2'd0);
      expect_out("post_reset", 8'h02, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
